// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DW-bit word, programmable divider, mode and cs gap.
// Build option SPI_LSB_FIRST_EN adds a per-transfer lsb_first input.
//
// state | meaning
// IDLE  | cs high, waiting for newd
// SETUP | cs low, one tick before the first sclk edge
// XFER  | 2*DW sclk toggles, sample/drive per CPHA
// HOLD  | one tick of cs low after the last edge, then done
// GAP   | CS_GAP ticks of cs high before the next accept
module spi_master_param #(
  parameter int DW      = 12,
  parameter int CLK_DIV = 2,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int CS_GAP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          newd,
`ifdef SPI_LSB_FIRST_EN
  input  logic          lsb_first,
`endif
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          busy,
  output logic          cs,
  output logic          sclk,
  output logic          mosi,
  input  logic          miso
);

  localparam int   DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   EDGE_W = $clog2(2 * DW);
  localparam int   GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic CPOL_B = (CPOL != 0);
  localparam logic CPHA_B = (CPHA != 0);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [EDGE_W-1:0] edge_cnt, edge_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [DW-1:0]     tx_sr, tx_nxt, rx_sr, rx_nxt, dout_nxt;
  logic              lsb_q, lsb_nxt, lsb_in;
  logic              cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic              tick;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(input logic [DW-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign tick = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      gap_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      lsb_q    <= 1'b0;
      dout     <= '0;
      cs       <= 1'b1;
      sclk     <= CPOL_B;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      edge_cnt <= edge_nxt;
      gap_cnt  <= gap_nxt;
      tx_sr    <= tx_nxt;
      rx_sr    <= rx_nxt;
      lsb_q    <= lsb_nxt;
      dout     <= dout_nxt;
      cs       <= cs_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    edge_nxt  = edge_cnt;
    gap_nxt   = gap_cnt;
    tx_nxt    = tx_sr;
    rx_nxt    = rx_sr;
    lsb_nxt   = lsb_q;
    dout_nxt  = dout;
    cs_nxt    = cs;
    sclk_nxt  = sclk;
    mosi_nxt  = mosi;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    if (state != IDLE) div_nxt = tick ? '0 : div_cnt + DIV_W'(1);

    unique case (state)
      IDLE: begin
        if (newd) begin
          state_nxt = SETUP;
          div_nxt   = '0;
          edge_nxt  = EDGE_W'(2 * DW - 1);
          cs_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          lsb_nxt   = lsb_in;
          rx_nxt    = '0;
          tx_nxt    = din;
          // CPHA=0 must present the first bit before the first (sampling) edge
          if (!CPHA_B) begin
            mosi_nxt = first_bit(din, lsb_in);
            tx_nxt   = shift_out(din, lsb_in);
          end
        end
      end
      SETUP: if (tick) state_nxt = XFER;
      XFER: begin
        if (tick) begin
          sclk_nxt = ~sclk;
          // edge_cnt counts down from 2*DW-1, so odd values are leading edges
          if (edge_cnt[0] ^ CPHA_B) begin
            rx_nxt = lsb_q ? {miso, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], miso};
          end else if (edge_cnt != '0) begin
            mosi_nxt = first_bit(tx_sr, lsb_q);
            tx_nxt   = shift_out(tx_sr, lsb_q);
          end
          if (edge_cnt == '0) state_nxt = HOLD;
          else edge_nxt = edge_cnt - EDGE_W'(1);
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = GAP;
          cs_nxt    = 1'b1;
          dout_nxt  = rx_sr;
          done_nxt  = 1'b1;
          gap_nxt   = GAP_W'(CS_GAP - 1);
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt == '0) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            gap_nxt = gap_cnt - GAP_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: a mode-0 instance (a_*) and a mode-3 instance (b_*)
// driven against behavioural SPI slave models; SPI_LSB_FIRST_EN enables the lsb-first test.
module tb_spi_master_param;

  localparam int A_DIV = 2, A_GAP = 1, B_DIV = 3, B_GAP = 2, W = 12;
  localparam int A_LAT_DONE = A_DIV * (2 * W + 2);
  localparam int A_LAT_BUSY = A_DIV * (2 * W + 2 + A_GAP);
  localparam int B_LAT_DONE = B_DIV * (2 * W + 2);
  localparam int B_LAT_BUSY = B_DIV * (2 * W + 2 + B_GAP);

  logic clk = 1'b0, rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  logic [11:0] a_din = '0, a_dout, a_sword = '0, a_srx = '0;
  logic        a_newd = 1'b0, a_done, a_busy, a_cs, a_sclk, a_mosi, a_miso;
  logic        a_loop = 1'b0, a_miso_s = 1'b0, a_first = 1'b0;
  logic        a_cs_prev = 1'b1, a_sclk_prev = 1'b0, a_busy_prev = 1'b0;
  int          a_edges = 0, a_rise = 0, a_cslow = 0, a_ndone = 0, a_tdone = 0, a_tbusy = 0, a_tacc = 0;

  logic [11:0] b_din = '0, b_dout, b_sword = '0, b_srx = '0;
  logic        b_newd = 1'b0, b_done, b_busy, b_cs, b_sclk, b_mosi, b_miso;
  logic        b_miso_s = 1'b0, b_cs_prev = 1'b1, b_sclk_prev = 1'b1, b_busy_prev = 1'b0;
  int          b_edges = 0, b_ndone = 0, b_tdone = 0, b_tbusy = 0, b_tacc = 0;
`ifdef SPI_LSB_FIRST_EN
  logic        a_lsb = 1'b0;
`endif

  assign a_miso = a_loop ? a_mosi : a_miso_s;
  assign b_miso = b_miso_s;

  spi_master_param #(.DW(W), .CLK_DIV(A_DIV), .CPOL(0), .CPHA(0), .CS_GAP(A_GAP)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .newd(a_newd),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(a_lsb),
`endif
    .dout(a_dout), .done(a_done), .busy(a_busy), .cs(a_cs), .sclk(a_sclk),
    .mosi(a_mosi), .miso(a_miso));

  spi_master_param #(.DW(W), .CLK_DIV(B_DIV), .CPOL(1), .CPHA(1), .CS_GAP(B_GAP)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .newd(b_newd),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .dout(b_dout), .done(b_done), .busy(b_busy), .cs(b_cs), .sclk(b_sclk),
    .mosi(b_mosi), .miso(b_miso));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: presents its MSB when cs falls, changes on trailing edges, samples on leading.
  always @(negedge clk) begin
    if (a_done) begin a_ndone++; a_tdone = cyc; end
    if (a_busy_prev && !a_busy) a_tbusy = cyc;
    a_busy_prev = a_busy;
    if (a_cs) a_edges = 0;
    else begin
      a_cslow++;
      if (a_cs_prev) begin a_srx = '0; a_miso_s = a_sword[11]; end
      if (a_sclk !== a_sclk_prev) begin
        a_edges++;
        if (a_sclk) a_rise++;
        if (a_edges % 2 == 1) begin
          a_srx = {a_srx[10:0], a_mosi};
          if (a_edges == 1) a_first = a_mosi;
        end else if (a_edges < 24) a_miso_s = a_sword[11 - a_edges / 2];
      end
    end
    a_cs_prev = a_cs; a_sclk_prev = a_sclk;
  end

  // Mode-3 slave: changes on leading edges, samples on trailing edges.
  always @(negedge clk) begin
    if (b_done) begin b_ndone++; b_tdone = cyc; end
    if (b_busy_prev && !b_busy) b_tbusy = cyc;
    b_busy_prev = b_busy;
    if (b_cs) b_edges = 0;
    else begin
      if (b_cs_prev) b_srx = '0;
      if (b_sclk !== b_sclk_prev) begin
        b_edges++;
        if (b_edges % 2 == 1) b_miso_s = b_sword[11 - (b_edges - 1) / 2];
        else b_srx = {b_srx[10:0], b_mosi};
      end
    end
    b_cs_prev = b_cs; b_sclk_prev = b_sclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_a(input logic [11:0] d, input logic [11:0] sw, input logic loop,
                       input int inj_at, input logic [11:0] inj_d);
    int n;
    @(negedge clk);
    a_din = d; a_sword = sw; a_loop = loop;
    a_ndone = 0; a_rise = 0; a_cslow = 0; a_tdone = -1; a_tbusy = -1;
    a_newd = 1'b1; a_tacc = cyc + 1;
    n = 0;
    do begin
      @(negedge clk); n++;
      a_newd = (inj_at > 0 && cyc == a_tacc + inj_at);
      if (a_newd) a_din = inj_d;
    end while (a_busy && n < 400);
    a_newd = 1'b0;
    @(negedge clk);
    chk("a_finished", n < 400, 1);
  endtask

  task automatic check_a(input logic [11:0] exp_dout, input logic [11:0] exp_rx);
    chk("a_dout", a_dout, exp_dout);
    chk("a_slave_rx", a_srx, exp_rx);
    chk("a_done_pulses", a_ndone, 1);
    chk("a_done_latency", a_tdone - a_tacc, A_LAT_DONE);
    chk("a_busy_latency", a_tbusy - a_tacc, A_LAT_BUSY);
    chk("a_sclk_rises", a_rise, 12);
    chk("a_cs_low_clks", a_cslow, A_LAT_DONE);
    chk("a_cs_idle", a_cs, 1);
  endtask

  task automatic run_check_b(input logic [11:0] d, input logic [11:0] sw);
    int n;
    @(negedge clk);
    b_din = d; b_sword = sw;
    b_ndone = 0; b_tdone = -1; b_tbusy = -1;
    b_newd = 1'b1; b_tacc = cyc + 1;
    @(negedge clk); b_newd = 1'b0;
    n = 0;
    while (b_busy && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b_finished", n < 400, 1);
    chk("b_dout", b_dout, sw);
    chk("b_slave_rx", b_srx, d);
    chk("b_done_pulses", b_ndone, 1);
    chk("b_done_latency", b_tdone - b_tacc, B_LAT_DONE);
    chk("b_busy_latency", b_tbusy - b_tacc, B_LAT_BUSY);
    chk("b_sclk_idle", b_sclk, 1);
  endtask

  initial begin
    int n;
    logic [11:0] d, sw;
    logic        lp;

    repeat (3) @(negedge clk);
    chk("rst_a_cs", a_cs, 1);
    chk("rst_a_sclk", a_sclk, 0);
    chk("rst_a_mosi", a_mosi, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_b_sclk", b_sclk, 1);
    chk("rst_b_cs", b_cs, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_a(12'hA5C, 12'h000, 1'b1, 0, 12'h000);
    check_a(12'hA5C, 12'hA5C);
    chk("a_first_bit", a_first, 1);

    run_check_b(12'h0F0, 12'h3C1);

    run_a(12'h456, 12'h000, 1'b1, 10, 12'h123);
    check_a(12'h456, 12'h456);
    repeat (10) @(negedge clk);
    chk("lockout_no_retrigger", a_busy, 0);
    chk("lockout_done_count", a_ndone, 1);

    run_a(12'h000, 12'hFFF, 1'b0, 0, 12'h000);
    check_a(12'hFFF, 12'h000);

    for (int i = 0; i < 5; i++) begin
      d = 12'($urandom); sw = 12'($urandom); lp = 1'($urandom_range(0, 1));
      run_a(d, sw, lp, 0, 12'h000);
      check_a(lp ? d : sw, d);
    end
    for (int i = 0; i < 3; i++) begin
      d = 12'($urandom); sw = 12'($urandom);
      run_check_b(d, sw);
    end

    // abort a transfer at its 7th sclk edge
    run_a(12'h9E7, 12'h000, 1'b1, 0, 12'h000);
    @(negedge clk);
    a_din = 12'hABC; a_loop = 1'b1; a_ndone = 0; a_newd = 1'b1;
    @(negedge clk); a_newd = 1'b0;
    n = 0;
    while (a_edges < 7 && n < 200) begin @(negedge clk); n++; end
    chk("rst_reach_edge7", n < 200, 1);
    rst = 1'b1;
    #1;
    chk("abort_cs", a_cs, 1);
    chk("abort_sclk", a_sclk, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_dout", a_dout, 0);
    chk("abort_done", a_done, 0);
    chk("abort_mosi", a_mosi, 0);
    @(negedge clk); rst = 1'b0;
    repeat (70) @(negedge clk);
    chk("abort_no_done", a_ndone, 0);
    chk("abort_dout_kept", a_dout, 0);
    run_a(12'h001, 12'h000, 1'b1, 0, 12'h000);
    check_a(12'h001, 12'h001);

`ifdef SPI_LSB_FIRST_EN
    a_lsb = 1'b1;
    run_a(12'h001, 12'h000, 1'b1, 0, 12'h000);
    check_a(12'h001, 12'h800);
    chk("lsb_first_bit", a_first, 1);
    a_lsb = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
